tone_generator_pulse_sweep: RTL and testbench

- Self-contained pulse voice: owns its phase accumulator, generates a PWM pulse output and can sweep pulse width automatically (ping-pong between two limits).
- Pulse width is double-buffered and only changes at accumulator wrap, so there are no mid-cycle duty glitches.
- Sits between the per-voice frequency/control registers and the voice mixer.
- Emits a one-cycle sync pulse at each wrap, for hard-syncing other voices.

---
 rtl/tone_generator_pulse_sweep.sv | 152 +++++++++++++++
 tb/tb_tone_generator_pulse_sweep.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator_pulse_sweep.sv
// Pulse voice: phase accumulator, wrap-synchronous PWM width and an optional ping-pong width sweep.
// Define TONE_PULSE_SYNC_EN to add the sync_in hard-sync input.
module tone_generator_pulse_sweep #(
    parameter int ACCUMULATOR_BITS = 24,
    parameter int FREQ_BITS        = 16,
    parameter int PULSEWIDTH_BITS  = 12,
    parameter int OUTPUT_BITS      = 12,
    parameter int SWEEP_STEP_BITS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [FREQ_BITS-1:0]       freq,
    input  logic [PULSEWIDTH_BITS-1:0] pulse_width,
    input  logic                       sweep_en,
    input  logic [SWEEP_STEP_BITS-1:0] sweep_step,
    input  logic [PULSEWIDTH_BITS-1:0] sweep_min,
    input  logic [PULSEWIDTH_BITS-1:0] sweep_max,
`ifdef TONE_PULSE_SYNC_EN
    input  logic                       sync_in,
`endif
    output logic [OUTPUT_BITS-1:0]     dout,
    output logic                       sync_out,
    output logic [PULSEWIDTH_BITS-1:0] pw_active
);

    localparam int AW = ACCUMULATOR_BITS;
    localparam int PW = PULSEWIDTH_BITS;
    localparam logic [PW-1:0] PW_RESET = PW'(32'd1 << (PW - 1));

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } sweep_state_t;

    sweep_state_t          r_state;
    sweep_state_t          w_state_next;
    sweep_state_t          w_stepped_state;
    logic [PW-1:0]         r_sweep;
    logic [PW-1:0]         w_sweep_next;
    logic [PW-1:0]         w_stepped;

    logic [AW-1:0]         r_acc;
    logic [OUTPUT_BITS-1:0] r_dout;
    logic                  r_sync;
    logic [PW-1:0]         r_pw_active;

    logic [AW:0]           w_sum;
    logic                  w_wrap;
    logic [AW-1:0]         w_acc_new;
    logic [PW:0]           w_step_ext;
    logic [PW:0]           w_up_sum;
    logic signed [PW:0]    w_down_diff;
    logic                  w_up_hit;
    logic                  w_down_hit;
    logic [PW-1:0]         w_pw_new;
    logic [PW-1:0]         w_pw_applied;
    logic                  w_dout_hi;

    // Phase accumulation: the extra top bit of the sum is the wrap carry.
    assign w_sum = {1'b0, r_acc} + (AW + 1)'(freq);

`ifdef TONE_PULSE_SYNC_EN
    // Hard sync beats the frequency add and behaves exactly like a natural wrap.
    assign w_wrap    = sample_en & (w_sum[AW] | sync_in);
    assign w_acc_new = sync_in ? '0 : w_sum[AW-1:0];
`else
    assign w_wrap    = sample_en & w_sum[AW];
    assign w_acc_new = w_sum[AW-1:0];
`endif

    // Sweep arithmetic one bit wider than the width so overshoot and undershoot are visible.
    assign w_step_ext  = (PW + 1)'(sweep_step);
    assign w_up_sum    = {1'b0, r_sweep} + w_step_ext;
    assign w_down_diff = $signed({1'b0, r_sweep}) - $signed(w_step_ext);
    assign w_up_hit    = (w_up_sum >= {1'b0, sweep_max});
    assign w_down_hit  = (w_down_diff <= $signed({1'b0, sweep_min}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_UP;
            r_sweep <= PW_RESET;
        end else begin
            r_state <= w_state_next;
            r_sweep <= w_sweep_next;
        end
    end

    always_comb begin
        w_stepped       = r_sweep;
        w_stepped_state = r_state;
        w_sweep_next    = r_sweep;
        w_state_next    = r_state;

        case (r_state)
            ST_UP: begin
                if (w_up_hit) begin
                    w_stepped       = sweep_max;
                    w_stepped_state = ST_DOWN;
                end else begin
                    w_stepped = w_up_sum[PW-1:0];
                end
            end
            ST_DOWN: begin
                if (w_down_hit) begin
                    w_stepped       = sweep_min;
                    w_stepped_state = ST_UP;
                end else begin
                    w_stepped = w_down_diff[PW-1:0];
                end
            end
            default: ;
        endcase

        // While the sweep is off it tracks the manual width, so enabling it starts from there.
        if (!sweep_en) begin
            w_sweep_next = pulse_width;
            w_state_next = ST_UP;
        end else if (w_wrap) begin
            w_sweep_next = w_stepped;
            w_state_next = w_stepped_state;
        end
    end

    // The new width is applied on the wrap sample itself, never mid-period.
    assign w_pw_new     = sweep_en ? w_stepped : pulse_width;
    assign w_pw_applied = w_wrap ? w_pw_new : r_pw_active;
    assign w_dout_hi    = (w_acc_new[AW-1 -: PW] <= w_pw_applied);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_dout      <= '0;
            r_sync      <= 1'b0;
            r_pw_active <= PW_RESET;
        end else begin
            r_sync <= w_wrap;
            if (sample_en) begin
                r_acc  <= w_acc_new;
                r_dout <= w_dout_hi ? '1 : '0;
                if (w_wrap) begin
                    r_pw_active <= w_pw_new;
                end
            end
        end
    end

    assign dout      = r_dout;
    assign sync_out  = r_sync;
    assign pw_active = r_pw_active;

endmodule

// File: tb/tb_tone_generator_pulse_sweep.sv
// Bench for tone_generator_pulse_sweep: integer reference model checked every cycle, plus directed literal checks.
module tb_tone_generator_pulse_sweep;

    localparam int AB = 8;
    localparam int FB = 8;
    localparam int PB = 4;
    localparam int OB = 4;
    localparam int SB = 4;
`ifdef TONE_PULSE_SYNC_EN
    localparam bit SYNC_FEAT = 1'b1;
`else
    localparam bit SYNC_FEAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_en;
    logic [FB-1:0] freq;
    logic [PB-1:0] pulse_width;
    logic          sweep_en;
    logic [SB-1:0] sweep_step;
    logic [PB-1:0] sweep_min;
    logic [PB-1:0] sweep_max;
    logic          sync_in;
    logic [OB-1:0] dout;
    logic          sync_out;
    logic [PB-1:0] pw_active;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // Reference model state (plain integers)
    int m_acc   = 0;
    int m_pw    = 8;
    int m_sweep = 8;
    int m_dout  = 0;
    bit m_up    = 1'b1;
    bit m_sync  = 1'b0;

    int exp_sw[7] = '{11, 12, 9, 6, 3, 2, 5};

    always #5 clk = ~clk;

    tone_generator_pulse_sweep #(
        .ACCUMULATOR_BITS(AB),
        .FREQ_BITS(FB),
        .PULSEWIDTH_BITS(PB),
        .OUTPUT_BITS(OB),
        .SWEEP_STEP_BITS(SB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_en(sample_en),
        .freq(freq),
        .pulse_width(pulse_width),
        .sweep_en(sweep_en),
        .sweep_step(sweep_step),
        .sweep_min(sweep_min),
        .sweep_max(sweep_max),
`ifdef TONE_PULSE_SYNC_EN
        .sync_in(sync_in),
`endif
        .dout(dout),
        .sync_out(sync_out),
        .pw_active(pw_active)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one sample period per clock edge, straight from the rules.
    always @(posedge clk) begin : model
        int s, t, v, pw_new, new_acc, d;
        bit wrap, up_new;
        if (!rst_n) begin
            m_acc   <= 0;
            m_dout  <= 0;
            m_sync  <= 1'b0;
            m_pw    <= 8;
            m_sweep <= 8;
            m_up    <= 1'b1;
        end else begin
            wrap    = 1'b0;
            new_acc = m_acc;
            pw_new  = m_pw;
            v       = m_sweep;
            up_new  = m_up;
            d       = m_dout;
            if (sample_en) begin
                if (SYNC_FEAT && sync_in) begin
                    new_acc = 0;
                    wrap    = 1'b1;
                end else begin
                    s       = m_acc + int'(freq);
                    wrap    = (s >= 256);
                    new_acc = s % 256;
                end
            end
            if (wrap) begin
                if (sweep_en) begin
                    if (m_up) begin
                        t = m_sweep + int'(sweep_step);
                        if (t >= int'(sweep_max)) begin v = int'(sweep_max); up_new = 1'b0; end
                        else v = t;
                    end else begin
                        t = m_sweep - int'(sweep_step);
                        if (t <= int'(sweep_min)) begin v = int'(sweep_min); up_new = 1'b1; end
                        else v = t;
                    end
                    pw_new = v;
                end else begin
                    pw_new = int'(pulse_width);
                end
            end
            if (!sweep_en) begin
                v      = int'(pulse_width);
                up_new = 1'b1;
            end
            if (sample_en) d = ((new_acc / 16) <= pw_new) ? 15 : 0;
            m_acc   <= new_acc;
            m_pw    <= pw_new;
            m_sweep <= v;
            m_up    <= up_new;
            m_sync  <= wrap;
            m_dout  <= d;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("dout", int'(dout), m_dout);
            check("sync_out", int'(sync_out), int'(m_sync));
            check("pw_active", int'(pw_active), m_pw);
        end
    end

    task automatic wait_sync();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sync_out) begin
                ok = 1'b1;
                break;
            end
        end
        check("sync_seen", int'(ok), 1);
    endtask

    task automatic cycles_to_sync(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (sync_out) break;
        end
    endtask

    initial begin
        int highs, syncs, n, hold_d, hold_pw;
        bit ok;
        rst_n = 1'b0; sample_en = 1'b1; freq = '0; pulse_width = 4'd7;
        sweep_en = 1'b0; sweep_step = '0; sweep_min = '0; sweep_max = 4'd15; sync_in = 1'b0;

        // Reset held for two clocks, then freq=0
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b1;
        check("rst_dout", int'(dout), 0);
        check("rst_sync", int'(sync_out), 0);
        check("rst_pw", int'(pw_active), 8);
        rst_n = 1'b1;
        syncs = 0;
        repeat (6) begin
            @(negedge clk);
            if (sync_out) syncs++;
        end
        check("f0_dout", int'(dout), 15);
        check("f0_pw", int'(pw_active), 8);
        check("f0_syncs", syncs, 0);

        // Fixed duty: freq=16, width 7
        freq = 8'd16;
        wait_sync();
        check("fd_pw", int'(pw_active), 7);
        highs = 0; syncs = 0;
        repeat (48) begin
            @(negedge clk);
            if (dout == 4'd15) highs++;
            if (sync_out) syncs++;
        end
        check("fd_highs", highs, 24);
        check("fd_syncs", syncs, 3);

        // Width change mid-period waits for the wrap
        highs = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 5) pulse_width = 4'd3;
            if (dout == 4'd15) highs++;
        end
        check("gl_old_highs", highs, 7);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("gl_sync", int'(sync_out), 1);
                check("gl_pw", int'(pw_active), 3);
            end
            if (dout == 4'd15) highs++;
        end
        check("gl_new_highs", highs, 4);

        // Sweep from seed 8, step 3, limits 2..12
        pulse_width = 4'd8;
        wait_sync();
        check("sw_seed_pw", int'(pw_active), 8);
        sweep_en = 1'b1; sweep_step = 4'd3; sweep_min = 4'd2; sweep_max = 4'd12;
        for (int k = 0; k < 7; k++) begin
            wait_sync();
            check("sw_pw", int'(pw_active), exp_sw[k]);
        end

        // Sample gap, then reset at acc=0x70
        sweep_en = 1'b0;
        repeat (3) @(negedge clk);
        hold_d = int'(dout); hold_pw = int'(pw_active);
        sample_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("gap_dout", int'(dout), hold_d);
            check("gap_pw", int'(pw_active), hold_pw);
            check("gap_sync", int'(sync_out), 0);
        end
        sample_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_acc == 'h70) begin ok = 1'b1; break; end
        end
        check("reach_0x70", int'(ok), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_dout", int'(dout), 0);
        check("mr_pw", int'(pw_active), 8);
        check("mr_sync", int'(sync_out), 0);
        rst_n = 1'b1;
        cycles_to_sync(n);
        check("mr_period", n, 16);

        // Hard sync (or plain period when the feature is absent)
        pulse_width = 4'd5;
`ifdef TONE_PULSE_SYNC_EN
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_acc == 'h50) begin ok = 1'b1; break; end
        end
        check("reach_0x50", int'(ok), 1);
        sync_in = 1'b1;
        @(negedge clk);
        sync_in = 1'b0;
        check("hs_sync", int'(sync_out), 1);
        check("hs_pw", int'(pw_active), 5);
        check("hs_dout", int'(dout), 15);
        cycles_to_sync(n);
        check("hs_period", n, 16);
`else
        wait_sync();
        check("ns_pw", int'(pw_active), 5);
        cycles_to_sync(n);
        check("ns_period", n, 16);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 199) != 0);
            sample_en = ($urandom_range(0, 3) != 0);
            sync_in   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 63) == 0) sweep_en = ~sweep_en;
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0: freq = '0;
                    1: freq = 8'($urandom_range(1, 32));
                    2: freq = 8'($urandom_range(33, 255));
                    default: freq = 8'd16;
                endcase
                pulse_width = 4'($urandom_range(0, 15));
                sweep_step  = 4'($urandom_range(0, 15));
                sweep_min   = 4'($urandom_range(0, 15));
                sweep_max   = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
